// File: rtl/thermostat_mode_fsm.sv
// Thermostat mode controller: registers set-point/sensor inputs and runs an
// OFF/IDLE/HEAT/COOL state machine with hysteresis, minimum dwell and blink.
module thermostat_mode_fsm #(
  parameter int TEMP_W    = 7,
  parameter int HYST      = 1,
  parameter int MIN_DWELL = 16,
  parameter int BLINK_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              temp_set,
  input  logic [TEMP_W-1:0] desired_temp,
  input  logic [TEMP_W-1:0] temp_in,
  output logic [2:0]        rgb_out,
  output logic              heat_on,
  output logic              cool_on,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_IDLE = 2'b01,
    ST_HEAT = 2'b10,
    ST_COOL = 2'b11
  } state_e;

  localparam int DW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0]     DWELL_LOAD = DW'(MIN_DWELL - 1);
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TEMP_W:0]   HYST_X     = (TEMP_W + 1)'(HYST);

  logic              s_q;
  logic [TEMP_W-1:0] d_q, t_q;
  state_e            state_q, state_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [2:0]        rgb_q, rgb_d;
  logic              heat_q, heat_d;
  logic              cool_q, cool_d;

  logic heat_req, cool_req, dwell_ok;
  logic heat_req_in, cool_req_in;
  logic entering_timed, leaving_timed;

  // Compares are one bit wider than the temperatures so t + HYST cannot wrap.
  assign heat_req    = {1'b0, d_q} > ({1'b0, t_q} + HYST_X);
  assign cool_req    = {1'b0, t_q} > ({1'b0, d_q} + HYST_X);
  assign heat_req_in = {1'b0, desired_temp} > ({1'b0, temp_in} + HYST_X);
  assign cool_req_in = {1'b0, temp_in} > ({1'b0, desired_temp} + HYST_X);
  assign dwell_ok    = (dwell_q == '0);

  always_comb begin
    state_d = state_q;
    if (!s_q) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_d = ST_IDLE;
        ST_IDLE: begin
          if (dwell_ok && heat_req)      state_d = ST_HEAT;
          else if (dwell_ok && cool_req) state_d = ST_COOL;
        end
        ST_HEAT: if (dwell_ok && (t_q >= d_q)) state_d = ST_IDLE;
        ST_COOL: if (dwell_ok && (t_q <= d_q)) state_d = ST_IDLE;
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign entering_timed = ((state_d == ST_HEAT) || (state_d == ST_COOL)) && (state_d != state_q);
  assign leaving_timed  = (state_d == ST_IDLE) && ((state_q == ST_HEAT) || (state_q == ST_COOL));

  always_comb begin
    dwell_d = '0;
    if (state_d == ST_OFF)                    dwell_d = '0;
    else if (entering_timed || leaving_timed) dwell_d = DWELL_LOAD;
    else if (dwell_q != '0)                   dwell_d = dwell_q - DW'(1);
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Outputs are registered from the next-state values so they track the state
  // register exactly while still clearing asynchronously on reset.
  always_comb begin
    rgb_d  = 3'b010;
    heat_d = 1'b0;
    cool_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        if (heat_req_in && (dwell_d != '0))      rgb_d = phase_d ? 3'b100 : 3'b010;
        else if (cool_req_in && (dwell_d != '0)) rgb_d = phase_d ? 3'b001 : 3'b010;
      end
      ST_HEAT: begin
        rgb_d  = 3'b100;
        heat_d = 1'b1;
      end
      ST_COOL: begin
        rgb_d  = 3'b001;
        cool_d = 1'b1;
      end
      default: rgb_d = 3'b010;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q         <= 1'b0;
      d_q         <= '0;
      t_q         <= '0;
      state_q     <= ST_OFF;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      rgb_q       <= 3'b000;
      heat_q      <= 1'b0;
      cool_q      <= 1'b0;
    end else begin
      s_q         <= temp_set;
      d_q         <= desired_temp;
      t_q         <= temp_in;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      rgb_q       <= rgb_d;
      heat_q      <= heat_d;
      cool_q      <= cool_d;
    end
  end

  assign rgb_out   = rgb_q;
  assign heat_on   = heat_q;
  assign cool_on   = cool_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_thermostat_mode_fsm.sv
// Bench for thermostat_mode_fsm: directed vector table, hand sequences for
// blink/dwell/reset corners, and randomized stimulus against a timeline model.
module tb_thermostat_mode_fsm;

  localparam int TEMP_W    = 7;
  localparam int HYST      = 2;
  localparam int MIN_DWELL = 8;
  localparam int BLINK_DIV = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              temp_set;
  logic [TEMP_W-1:0] desired_temp;
  logic [TEMP_W-1:0] temp_in;
  logic [2:0]        rgb_out;
  logic              heat_on;
  logic              cool_on;
  logic [1:0]        state_out;

  int errors = 0;
  int checks = 0;

  thermostat_mode_fsm #(
    .TEMP_W(TEMP_W), .HYST(HYST), .MIN_DWELL(MIN_DWELL), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .temp_set(temp_set),
    .desired_temp(desired_temp), .temp_in(temp_in),
    .rgb_out(rgb_out), .heat_on(heat_on), .cool_on(cool_on), .state_out(state_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Mode timeline: edges since reset, edge of the last dwell-loading entry.
  int n;
  int entry_e;
  int m_mode;   // 0 OFF, 1 IDLE, 2 HEAT, 3 COOL
  bit m_s;
  int m_d, m_t;

  task automatic model_reset();
    n = 0; entry_e = -1000; m_mode = 0; m_s = 0; m_d = 0; m_t = 0;
  endtask

  task automatic model_edge(input bit s, input int d, input int t);
    bit ok, hr, cr;
    int nxt;
    n++;
    ok  = (n - 1 - entry_e) >= MIN_DWELL - 1;
    hr  = m_d > m_t + HYST;
    cr  = m_t > m_d + HYST;
    nxt = m_mode;
    if (!m_s) nxt = 0;
    else if (m_mode == 0) nxt = 1;
    else if (m_mode == 1) begin
      if (ok && hr) nxt = 2;
      else if (ok && cr) nxt = 3;
    end else if (m_mode == 2) begin
      if (ok && m_t >= m_d) nxt = 1;
    end else if (ok && m_t <= m_d) nxt = 1;
    if (nxt == 0) entry_e = -1000;
    else if ((nxt >= 2 && nxt != m_mode) || (nxt == 1 && m_mode >= 2)) entry_e = n;
    m_mode = nxt; m_s = s; m_d = d; m_t = t;
  endtask

  function automatic logic [6:0] model_out();
    logic [2:0] rgb;
    logic h, c;
    bit ok, ph, hr, cr;
    logic [1:0] st;
    ok = (n - entry_e) >= MIN_DWELL - 1;
    ph = ((n / BLINK_DIV) % 2) == 1;
    hr = m_d > m_t + HYST;
    cr = m_t > m_d + HYST;
    rgb = 3'b010; h = 1'b0; c = 1'b0;
    if (m_mode == 1) begin
      if (hr && !ok)      rgb = ph ? 3'b100 : 3'b010;
      else if (cr && !ok) rgb = ph ? 3'b001 : 3'b010;
    end else if (m_mode == 2) begin
      rgb = 3'b100; h = 1'b1;
    end else if (m_mode == 3) begin
      rgb = 3'b001; c = 1'b1;
    end
    st = 2'(m_mode);
    return {st, rgb, h, c};
  endfunction

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input bit s, input int d, input int t);
    temp_set     = s;
    desired_temp = 7'(d);
    temp_in      = 7'(t);
    @(posedge clk);
    model_edge(s, d, t);
    exp_q.push_back(model_out());
    #2;
    check("model", {25'd0, state_out, rgb_out, heat_on, cool_on}, {25'd0, exp_q.pop_front()});
    check("relay_excl", {31'd0, heat_on & cool_on}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    temp_set = 1'b0; desired_temp = '0; temp_in = '0;
    #1;
    check("reset_outputs", {25'd0, state_out, rgb_out, heat_on, cool_on}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       s;
    int         d;
    int         t;
    int         cycles;
    logic [2:0] rgb;
    logic       heat;
    logic       cool;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  task automatic add_vec(input logic s, input int d, input int t, input int cyc,
                         input logic [2:0] rgb, input logic h, input logic c, input logic [1:0] st);
    vecs[nvec] = '{s, d, t, cyc, rgb, h, c, st};
    nvec++;
  endtask

  task automatic run_vec(input int i);
    repeat (vecs[i].cycles) tick(vecs[i].s, vecs[i].d, vecs[i].t);
    check($sformatf("vec%0d", i), {25'd0, state_out, rgb_out, heat_on, cool_on},
          {25'd0, vecs[i].st, vecs[i].rgb, vecs[i].heat, vecs[i].cool});
  endtask

  int vals[6] = '{0, 1, 2, 125, 126, 127};

  initial begin
    int seen_h, seen_g, bad;
    nvec = 0;
    add_vec(1, 70, 70, 2,  3'b010, 0, 0, 2'b01);  // enable -> IDLE after 2 edges
    add_vec(1, 72, 70, 3,  3'b010, 0, 0, 2'b01);  // exactly at band edge
    add_vec(1, 73, 70, 2,  3'b100, 1, 0, 2'b10);  // heat request
    add_vec(1, 73, 75, 1,  3'b100, 1, 0, 2'b10);  // satisfied, dwell holds
    add_vec(1, 73, 75, 6,  3'b100, 1, 0, 2'b10);
    add_vec(1, 73, 75, 1,  3'b010, 0, 0, 2'b01);  // dwell expired -> IDLE
    add_vec(1, 60, 70, 20, 3'b001, 0, 1, 2'b11);  // via IDLE into COOL
    add_vec(0, 60, 70, 2,  3'b010, 0, 0, 2'b00);  // disable ignores dwell
    add_vec(1, 60, 70, 2,  3'b010, 0, 0, 2'b01);
    add_vec(1, 60, 70, 1,  3'b001, 0, 1, 2'b11);
    add_vec(0, 60, 70, 1,  3'b001, 0, 1, 2'b11);  // one-cycle disable pulse
    add_vec(1, 60, 70, 1,  3'b010, 0, 0, 2'b00);
    add_vec(1, 60, 70, 1,  3'b010, 0, 0, 2'b01);
    add_vec(1, 60, 70, 1,  3'b001, 0, 1, 2'b11);

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(i);

    // Heat demand held off by the dwell timer: LED must blink red/green.
    seen_h = 0; seen_g = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 73, 60);
      if (rgb_out == 3'b100) seen_h++;
      else if (rgb_out == 3'b010) seen_g++;
      else bad++;
      if (heat_on) bad++;
    end
    check("blink_bad", bad, 0);
    check("blink_both", {30'd0, seen_h > 0, seen_g > 0}, 32'd3);
    tick(1, 73, 60);
    check("dwell_end_idle", {27'd0, state_out, rgb_out}, {27'd0, 2'b01, 3'b010});
    tick(1, 73, 60);
    check("dwell_end_heat", {26'd0, state_out, rgb_out, heat_on}, {26'd0, 2'b10, 3'b100, 1'b1});

    for (int i = 6; i < nvec; i++) run_vec(i);

    // Asynchronous reset mid-COOL, between clock edges.
    reset = 1'b1;
    #1;
    check("async_reset", {25'd0, state_out, rgb_out, heat_on, cool_on}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Extremes sweep.
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        repeat (3) tick(1, vals[i], vals[j]);

    // Randomized run.
    do_reset();
    for (int blk = 0; blk < 120; blk++) begin
      int d, t, hold;
      bit s;
      s = ($urandom_range(0, 15) != 0);
      d = $urandom_range(0, 127);
      if ($urandom_range(0, 3) == 0) t = $urandom_range(0, 127);
      else begin
        t = d + $urandom_range(0, 10) - 5;
        if (t < 0) t = 0;
        if (t > 127) t = 127;
      end
      hold = $urandom_range(1, 20);
      repeat (hold) tick(s, d, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
